// File: rtl/hms_ctrl_pkg.sv
// Shared definitions for the HMS mode/setup controller.
// Holds the mode and position encodings, the display blink-mask constants
// and a helper that maps the selected field and blink phase to a digit mask.
package hms_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC = 2'd0,
    POS_MIN = 2'd1,
    POS_HR  = 2'd2
  } pos_e;

  // 1 = digit enabled; [1:0] sec, [3:2] min, [5:4] hr
  localparam logic [5:0] MASK_ALL_ON  = 6'b111111;
  localparam logic [5:0] MASK_SEC_OFF = 6'b111100;
  localparam logic [5:0] MASK_MIN_OFF = 6'b110011;
  localparam logic [5:0] MASK_HR_OFF  = 6'b001111;

  // Digit mask for a blinking field: phase 1 blanks the selected field only.
  function automatic logic [5:0] blink_mask(input pos_e pos, input logic phase);
    logic [5:0] m;
    m = MASK_ALL_ON;
    if (phase) begin
      case (pos)
        POS_SEC: m = MASK_SEC_OFF;
        POS_MIN: m = MASK_MIN_OFF;
        POS_HR:  m = MASK_HR_OFF;
        default: m = MASK_ALL_ON;
      endcase
    end else begin
      m = MASK_ALL_ON;
    end
    return m;
  endfunction

endpackage

// File: rtl/hms_mode_ctrl_if.sv
// Signal bundle between the debouncers/timebase, hms_mode_ctrl and the
// hms counters / led_disp.
//   master : drives the strobes, button levels and counter-at-max flags,
//            observes mode, position, inc enables, digit mask and buzzer.
//   slave  : the controller side (hms_mode_ctrl).
interface hms_mode_ctrl_if;
  logic       i_tick_1hz;
  logic       i_tick_blink;
  logic       i_sw_mode;
  logic       i_sw_pos;
  logic       i_sw_inc;
  logic       i_sec_max;
  logic       i_min_max;
  logic       i_alarm_hit;
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hr_inc;
  logic       o_alm_min_inc;
  logic       o_alm_hr_inc;
  logic [5:0] o_seg_enb_mask;
  logic       o_buzz;

  modport master (
    output i_tick_1hz, i_tick_blink, i_sw_mode, i_sw_pos, i_sw_inc,
           i_sec_max, i_min_max, i_alarm_hit,
    input  o_mode, o_position, o_sec_inc, o_min_inc, o_hr_inc,
           o_alm_min_inc, o_alm_hr_inc, o_seg_enb_mask, o_buzz
  );

  modport slave (
    input  i_tick_1hz, i_tick_blink, i_sw_mode, i_sw_pos, i_sw_inc,
           i_sec_max, i_min_max, i_alarm_hit,
    output o_mode, o_position, o_sec_inc, o_min_inc, o_hr_inc,
           o_alm_min_inc, o_alm_hr_inc, o_seg_enb_mask, o_buzz
  );
endinterface

// File: rtl/hms_mode_ctrl_btn_edge.sv
// btn_edge: one-bit rising-edge detector for a debounced button level.
// Ports: clk, rst (async, active high), level_i (debounced level),
//        press_o (high in the cycle the level is 1 and the previous level was 0).
// The history register resets to 1 so a button held through reset does not
// produce a press until it has been released and pressed again.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic press_o
);

  logic prev_q;

  // Previous-cycle level of the button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_i;
    end
  end

  assign press_o = level_i & ~prev_q;

endmodule

// File: rtl/hms_mode_ctrl.sv
// hms_mode_ctrl: mode/setup controller for the HMS clock datapath.
// Turns 1 Hz / blink strobes and debounced buttons into single-cycle
// increment enables, owns the sec->min->hr carry chain, setup position
// selection, display blink mask and (optionally) the alarm buzzer.
// Ports: clk, rst (async, active high), bus (hms_mode_ctrl_if.slave):
//   inputs  i_tick_1hz, i_tick_blink, i_sw_mode/pos/inc, i_sec_max,
//           i_min_max, i_alarm_hit
//   outputs o_mode, o_position, o_sec/min/hr_inc, o_alm_min/hr_inc,
//           o_seg_enb_mask, o_buzz (all registered)
// Build option: HMS_MODE_CTRL_ALARM_EN adds the ALARM_SET mode, alarm inc
// outputs and the buzzer; without it those outputs are tied to 0.
module hms_mode_ctrl
  import hms_ctrl_pkg::*;
#(
  parameter int BUZZ_SECS = 30
) (
  input  logic           clk,
  input  logic           rst,
  hms_mode_ctrl_if.slave bus
);

  logic mode_evt_s, pos_evt_s, inc_evt_s;
  logic inc_act_s, clk_tick_s, set_inc_s;

  mode_e mode_q, mode_d;
  pos_e  pos_q, pos_d;
  logic  phase_q, phase_d;
  logic  sec_inc_q, sec_inc_d;
  logic  min_inc_q, min_inc_d;
  logic  hr_inc_q, hr_inc_d;
  logic [5:0] mask_q, mask_d;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .level_i(bus.i_sw_mode), .press_o(mode_evt_s));
  btn_edge u_edge_pos  (.clk(clk), .rst(rst), .level_i(bus.i_sw_pos),  .press_o(pos_evt_s));
  btn_edge u_edge_inc  (.clk(clk), .rst(rst), .level_i(bus.i_sw_inc),  .press_o(inc_evt_s));

  // An inc press only acts when no higher-priority press shares the cycle.
  assign inc_act_s  = inc_evt_s & ~mode_evt_s & ~pos_evt_s;
  // The mode after this edge decides whether the tick advances time.
  assign clk_tick_s = (mode_d == MODE_CLOCK) & bus.i_tick_1hz;
  assign set_inc_s  = inc_act_s & (mode_q == MODE_SETUP);

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_CLOCK;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next mode on a mode press.
  always_comb begin
    mode_d = mode_q;
    if (mode_evt_s) begin
      case (mode_q)
        MODE_CLOCK: mode_d = MODE_SETUP;
`ifdef HMS_MODE_CTRL_ALARM_EN
        MODE_SETUP: mode_d = MODE_ALARM;
`else
        MODE_SETUP: mode_d = MODE_CLOCK;
`endif
        MODE_ALARM: mode_d = MODE_CLOCK;
        default:    mode_d = MODE_CLOCK;
      endcase
    end else begin
      mode_d = mode_q;
    end
  end

  // Next position, blink phase, time inc enables and digit mask.
  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (mode_evt_s) begin
      pos_d = (mode_d == MODE_ALARM) ? POS_MIN : POS_SEC;
    end else if (pos_evt_s) begin
      case (mode_q)
        MODE_SETUP: begin
          case (pos_q)
            POS_SEC: pos_d = POS_MIN;
            POS_MIN: pos_d = POS_HR;
            default: pos_d = POS_SEC;
          endcase
        end
        MODE_ALARM: pos_d = (pos_q == POS_HR) ? POS_MIN : POS_HR;
        default:    pos_d = pos_q;
      endcase
    end else begin
      pos_d = pos_q;
    end

    // Blink runs independently of button presses but restarts on a mode change.
    if (mode_evt_s) begin
      phase_d = 1'b0;
    end else if ((mode_q != MODE_CLOCK) && bus.i_tick_blink) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end

    sec_inc_d = clk_tick_s | (set_inc_s & (pos_q == POS_SEC));
    min_inc_d = (clk_tick_s & bus.i_sec_max) | (set_inc_s & (pos_q == POS_MIN));
    hr_inc_d  = (clk_tick_s & bus.i_sec_max & bus.i_min_max) | (set_inc_s & (pos_q == POS_HR));

    if (mode_d == MODE_CLOCK) begin
      mask_d = MASK_ALL_ON;
    end else begin
      mask_d = blink_mask(pos_d, phase_d);
    end
  end

  // Registered outputs and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= POS_SEC;
      phase_q   <= 1'b0;
      sec_inc_q <= 1'b0;
      min_inc_q <= 1'b0;
      hr_inc_q  <= 1'b0;
      mask_q    <= MASK_ALL_ON;
    end else begin
      pos_q     <= pos_d;
      phase_q   <= phase_d;
      sec_inc_q <= sec_inc_d;
      min_inc_q <= min_inc_d;
      hr_inc_q  <= hr_inc_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.o_mode         = mode_q;
  assign bus.o_position     = pos_q;
  assign bus.o_sec_inc      = sec_inc_q;
  assign bus.o_min_inc      = min_inc_q;
  assign bus.o_hr_inc       = hr_inc_q;
  assign bus.o_seg_enb_mask = mask_q;

`ifdef HMS_MODE_CTRL_ALARM_EN
  localparam int CW = $clog2(BUZZ_SECS + 1);

  logic          alm_inc_s;
  logic          any_evt_s;
  logic          alm_min_inc_q, alm_min_inc_d;
  logic          alm_hr_inc_q, alm_hr_inc_d;
  logic          buzz_q, buzz_d;
  logic [CW-1:0] buzz_cnt_q, buzz_cnt_d;

  assign alm_inc_s = inc_act_s & (mode_q == MODE_ALARM);
  assign any_evt_s = mode_evt_s | pos_evt_s | inc_evt_s;

  // Alarm inc enables and buzzer countdown.
  always_comb begin
    alm_min_inc_d = alm_inc_s & (pos_q == POS_MIN);
    alm_hr_inc_d  = alm_inc_s & (pos_q == POS_HR);
    buzz_d        = buzz_q;
    buzz_cnt_d    = buzz_cnt_q;
    if (mode_d != MODE_CLOCK) begin
      buzz_d     = 1'b0;
      buzz_cnt_d = '0;
    end else if (bus.i_alarm_hit) begin
      buzz_d     = 1'b1;
      buzz_cnt_d = CW'(BUZZ_SECS);
    end else if (any_evt_s) begin
      buzz_d     = 1'b0;
      buzz_cnt_d = '0;
    end else if (buzz_q && bus.i_tick_1hz) begin
      // The buzzer drops on the tick that takes the count to zero.
      buzz_cnt_d = buzz_cnt_q - CW'(1);
      buzz_d     = (buzz_cnt_q != CW'(1));
    end else begin
      buzz_d     = buzz_q;
      buzz_cnt_d = buzz_cnt_q;
    end
  end

  // Alarm output and buzzer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_min_inc_q <= 1'b0;
      alm_hr_inc_q  <= 1'b0;
      buzz_q        <= 1'b0;
      buzz_cnt_q    <= '0;
    end else begin
      alm_min_inc_q <= alm_min_inc_d;
      alm_hr_inc_q  <= alm_hr_inc_d;
      buzz_q        <= buzz_d;
      buzz_cnt_q    <= buzz_cnt_d;
    end
  end

  assign bus.o_alm_min_inc = alm_min_inc_q;
  assign bus.o_alm_hr_inc  = alm_hr_inc_q;
  assign bus.o_buzz        = buzz_q;
`else
  logic unused_alarm_s;
  assign unused_alarm_s = bus.i_alarm_hit ^ (BUZZ_SECS > 0);

  assign bus.o_alm_min_inc = 1'b0;
  assign bus.o_alm_hr_inc  = 1'b0;
  assign bus.o_buzz        = 1'b0;
`endif

endmodule

// File: doc/hms_mode_ctrl.md
# hms_mode_ctrl

Synchronous mode/setup controller for the HMS clock datapath. Replaces gated-clock switching: it turns 1 Hz ticks and debounced button levels into single-cycle increment enables for the sec/min/hr counters. It owns the carry chain, setup-position selection and the display blink mask. It sits between the debouncers and the hms counters / led_disp.

## Interface
- Parameters:
- BUZZ_SECS, 30: alarm buzzer duration in 1 Hz ticks (ALARM_EN only).
- Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- i_tick_1hz  in  1  one-cycle strobe, 1 Hz
- i_tick_blink  in  1  one-cycle strobe, blink half-period (2 Hz)
- i_sw_mode  in  1  debounced level, 1 = pressed
- i_sw_pos  in  1  debounced level, 1 = pressed
- i_sw_inc  in  1  debounced level, 1 = pressed
- i_sec_max  in  1  seconds counter currently at 59
- i_min_max  in  1  minutes counter currently at 59
- i_alarm_hit  in  1  one-cycle strobe: time equals alarm (ALARM_EN only)
- o_mode  out  2  0 = CLOCK, 1 = SETUP, 2 = ALARM_SET
- o_position  out  2  0 = SEC, 1 = MIN, 2 = HR
- o_sec_inc / o_min_inc / o_hr_inc  out  1 each  one-cycle time-counter enables
- o_alm_min_inc / o_alm_hr_inc  out  1 each  one-cycle alarm-register enables
- o_seg_enb_mask  out  6  1 = digit enabled; [1:0] sec, [3:2] min, [5:4] hr
- o_buzz  out  1  buzzer drive

## Operation
- Button edges: each button is registered once. A press event is the current level = 1 with the previous level = 0. The previous-level registers reset to 1, so a button held through reset gives no event until it is released and pressed again.
- Mode FSM. States are CLOCK, SETUP and ALARM_SET.
  - A mode press moves CLOCK→SETUP→ALARM_SET→CLOCK (without ALARM_EN: CLOCK↔SETUP).
  - Entering any state sets o_position to SEC (ALARM_SET: MIN) and blink phase to 0.
- Priority in one cycle: mode press > pos press > inc press. A lower-priority event in the same cycle is dropped.
- Position:
  - SETUP: a pos press cycles SEC→MIN→HR→SEC.
  - ALARM_SET: a pos press cycles MIN↔HR.
  - CLOCK: pos presses are ignored.
- CLOCK mode:
  - On i_tick_1hz, pulse o_sec_inc.
  - o_min_inc = o_sec_inc & i_sec_max.
  - o_hr_inc = o_min_inc & i_min_max.
  - Inc presses are ignored.
- SETUP mode:
  - i_tick_1hz is ignored, so time is frozen.
  - An inc press pulses only the inc output of the selected field, with no carry.
- ALARM_SET mode: an inc press pulses o_alm_min_inc or o_alm_hr_inc. Time counters are frozen.
- Blink:
  - In SETUP or ALARM_SET, i_tick_blink toggles the phase.
  - Phase 1 clears the two mask bits of the selected field; all other bits stay 1.
  - In CLOCK the mask is 6'b111111.
- Buzzer:
  - i_alarm_hit in CLOCK mode sets o_buzz and loads a down-counter with BUZZ_SECS.
  - The counter decrements on i_tick_1hz. o_buzz clears when it reaches 0, on any button press event, or on leaving CLOCK.
  - An i_alarm_hit while buzzing reloads the counter.

## Timing
- Reset values:
  - o_mode = 0, o_position = 0.
  - All inc outputs 0.
  - o_seg_enb_mask = 6'b111111.
  - o_buzz = 0, blink phase 0, buzz counter 0.
- Reset mid-operation takes effect immediately (asynchronous) and aborts any pending pulse.
- All outputs are registered.
- Latency is 1 cycle: a strobe or press sampled at edge N is visible after edge N; each inc pulse lasts exactly one cycle.
- A carry uses the i_sec_max / i_min_max values sampled at the same edge as the tick.
- A mode change and a tick at the same edge: the new mode governs, so a tick arriving with CLOCK→SETUP produces no pulse.
- Mask and o_position update on the same edge as the event.

## Configuration
- Macro: HMS_MODE_CTRL_ALARM_EN.
- Defined: ALARM_SET state, the alarm inc outputs, o_buzz and the buzz counter exist.
- Undefined: those ports still exist but are tied to 0, i_alarm_hit is ignored, and o_mode never takes value 2.

## Structure
- Shared package hms_ctrl_pkg holds:
  - mode encodings MODE_CLOCK/MODE_SETUP/MODE_ALARM;
  - position encodings POS_SEC/POS_MIN/POS_HR;
  - mask constants MASK_ALL_ON, MASK_SEC_OFF, MASK_MIN_OFF, MASK_HR_OFF.
- One sub-module, btn_edge: a one-bit registered rising-edge detector with reset-to-1 history, instantiated three times.

## Test plan
- Reset, then 3 × i_tick_1hz with i_sec_max = 0 → three single-cycle o_sec_inc pulses, no o_min_inc, mask = 6'b111111.
- i_tick_1hz with i_sec_max = 1 and i_min_max = 1 → o_sec_inc, o_min_inc and o_hr_inc high in the same single cycle.
- Mode press, pos press, 2 × blink tick, inc press:
  - o_mode = 1, o_position = 1;
  - mask goes 6'b110011 then 6'b111111;
  - one o_min_inc pulse and no o_sec_inc despite concurrent 1 Hz ticks.
- Mode and inc pressed in the same cycle while in SETUP:
  - ALARM_EN: o_mode = 2, o_position = 1, no inc pulse.
  - Without ALARM_EN: o_mode = 0, no inc pulse.
- i_sw_inc held at 1 across reset deassert → no pulse; release and re-press in SETUP → exactly one pulse.
- ALARM_EN, BUZZ_SECS = 3: i_alarm_hit in CLOCK → o_buzz high for 3 ticks, then low. Repeat and press pos at tick 1 → o_buzz low the next cycle.
